// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes,
// control-state encoding and small decode helpers.
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    // True for the four long-latency operations that occupy the unit.
    function automatic logic op_is_arith(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit with architectural HI/LO registers. The result is
// computed at acceptance and held in temp registers; it is committed to
// HI/LO when the Busy countdown completes, modelling multi-cycle latency.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOut
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    mdu_state_e  state, state_n;
    logic [CW-1:0] count, count_n;
    logic [31:0] hi_n, lo_n;
    logic [31:0] temp_hi, temp_lo, temp_hi_n, temp_lo_n;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, q_mag, r_mag;
    logic [31:0] quo_s, rem_s, quo_u, rem_u;

    // Arithmetic datapath: products and quotients of the current operands.
    // Signed division works on magnitudes so INT_MIN / -1 wraps to INT_MIN
    // with a zero remainder instead of overflowing.
    always_comb begin
        prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u = {32'b0, A} * {32'b0, B};
        a_mag  = A[31] ? (32'd0 - A) : A;
        b_mag  = B[31] ? (32'd0 - B) : B;
        q_mag  = (b_mag == '0) ? '0 : a_mag / b_mag;
        r_mag  = (b_mag == '0) ? '0 : a_mag % b_mag;
        quo_s  = (A[31] ^ B[31]) ? (32'd0 - q_mag) : q_mag;
        rem_s  = A[31] ? (32'd0 - r_mag) : r_mag;
        quo_u  = (B == '0) ? '0 : A / B;
        rem_u  = (B == '0) ? '0 : A % B;
    end

    // Next-state logic: acceptance, countdown, commit and HI/LO moves.
    always_comb begin
        state_n   = state;
        count_n   = count;
        hi_n      = HI;
        lo_n      = LO;
        temp_hi_n = temp_hi;
        temp_lo_n = temp_lo;
        case (state)
            ST_IDLE: begin
                if (MDUOp == OP_MTHI) hi_n = A;
                if (MDUOp == OP_MTLO) lo_n = A;
                if (Start && op_is_arith(MDUOp)) begin
                    state_n = ST_BUSY;
                    count_n = op_is_div(MDUOp) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    // Divide by zero commits the current HI/LO, leaving them unchanged.
                    temp_hi_n = HI;
                    temp_lo_n = LO;
                    case (MDUOp)
                        OP_MULT:  {temp_hi_n, temp_lo_n} = prod_s;
                        OP_MULTU: {temp_hi_n, temp_lo_n} = prod_u;
                        OP_DIV:   if (B != '0) {temp_hi_n, temp_lo_n} = {rem_s, quo_s};
                        OP_DIVU:  if (B != '0) {temp_hi_n, temp_lo_n} = {rem_u, quo_u};
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                if (count == CW'(1)) begin
                    state_n = ST_IDLE;
                    count_n = '0;
                    hi_n    = temp_hi;
                    lo_n    = temp_lo;
                end else begin
                    count_n = count - CW'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            count   <= '0;
            HI      <= '0;
            LO      <= '0;
            temp_hi <= '0;
            temp_lo <= '0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            HI      <= hi_n;
            LO      <= lo_n;
            temp_hi <= temp_hi_n;
            temp_lo <= temp_lo_n;
        end
    end

    assign Busy = (state == ST_BUSY);

    // Zero-latency read port for MFHI/MFLO.
    always_comb begin
        MDUOut = '0;
        if (MDUOp == OP_MFHI) MDUOut = HI;
        if (MDUOp == OP_MFLO) MDUOut = LO;
    end

endmodule
